// File: rtl/fir_accel_pkg.sv
// Shared definitions for the memory-mapped FIR accelerator: FSM encoding,
// command/status field positions and the default coefficient set.
package fir_accel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CALC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int CMD_REQ_BIT   = 0;
    localparam int CMD_ABORT_BIT = 1;
    localparam int CMD_LEN_LSB   = 16;
    localparam int LEN_W         = 16;

    localparam int STS_ACK_BIT   = 0;
    localparam int STS_BUSY_BIT  = 1;
    localparam int STS_ERR_BIT   = 2;
    localparam int STS_CNT_LSB   = 16;
    localparam int CNT_W         = 16;

    localparam int DEFAULT_NUM_TAPS = 3;
    localparam int DEFAULT_COEF_W   = 8;
    localparam logic [DEFAULT_NUM_TAPS*DEFAULT_COEF_W-1:0] DEFAULT_COEFS =
        {8'sd1, 8'sd2, 8'sd1};

    function automatic logic [31:0] pack_status(input logic             ack,
                                                input logic             busy,
                                                input logic             error,
                                                input logic [CNT_W-1:0] count);
        logic [31:0] s;
        s                          = '0;
        s[STS_ACK_BIT]             = ack;
        s[STS_BUSY_BIT]            = busy;
        s[STS_ERR_BIT]             = error;
        s[STS_CNT_LSB +: CNT_W]    = count;
        return s;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// FIR datapath: tap history, signed multiply-accumulate, arithmetic shift and
// output narrowing. Define MM_FIR_ACCEL_SAT_EN to saturate instead of wrap.
module fir_mac
    import fir_accel_pkg::*;
#(
    parameter int                            DATA_W   = 32,
    parameter int                            COEF_W   = DEFAULT_COEF_W,
    parameter int                            NUM_TAPS = DEFAULT_NUM_TAPS,
    parameter logic [NUM_TAPS*COEF_W-1:0]    COEFS    = DEFAULT_COEFS,
    parameter int                            SHIFT    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] result
);

    localparam int ACC_W  = DATA_W + COEF_W + $clog2(NUM_TAPS);
    localparam int HIST_D = (NUM_TAPS > 1) ? NUM_TAPS - 1 : 1;

    logic signed [DATA_W-1:0] hist_q [HIST_D];
    logic signed [DATA_W-1:0] taps   [NUM_TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;
    logic        [DATA_W-1:0] y;

    // taps[0] is the sample being shifted in this cycle, taps[k] is x[i-k].
    always_comb begin
        taps[0] = sample;
        for (int k = 1; k < NUM_TAPS; k++) begin
            taps[k] = hist_q[k-1];
        end
    end

    // NOTE: every variable is assigned before any conditional use, so no latch
    // is inferred; the accumulator is wide enough that no partial sum overflows.
    always_comb begin
        acc = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            acc = acc + ACC_W'(taps[k]) * ACC_W'($signed(COEFS[k*COEF_W +: COEF_W]));
        end
        shifted = acc >>> SHIFT;
    end

`ifdef MM_FIR_ACCEL_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - ACC_W'(1);

    always_comb begin
        y = shifted[DATA_W-1:0];
        if (shifted > Y_MAX) begin
            y = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < Y_MIN) begin
            y = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end
`else
    assign y = DATA_W'(shifted);
`endif

    // NOTE: the history is a few plain registers rather than a RAM, so it takes
    // the async reset; state updates use non-blocking assignments throughout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < HIST_D; k++) begin
                hist_q[k] <= '0;
            end
            result <= '0;
        end else if (clear) begin
            for (int k = 0; k < HIST_D; k++) begin
                hist_q[k] <= '0;
            end
        end else if (load) begin
            hist_q[0] <= taps[0];
            for (int k = 1; k < HIST_D; k++) begin
                hist_q[k] <= hist_q[k-1];
            end
            result <= y;
        end
    end

endmodule

// File: rtl/mm_fir_accel.sv
// Avalon-MM FIR accelerator: reads N samples from SRC_BASE, filters them and
// writes the results to DST_BASE, one read/compute/write triple per sample.
module mm_fir_accel
    import fir_accel_pkg::*;
#(
    parameter int                            DATA_W      = 32,
    parameter int                            ADDR_W      = 10,
    parameter int                            MAX_SAMPLES = 1024,
    parameter int                            NUM_TAPS    = DEFAULT_NUM_TAPS,
    parameter int                            COEF_W      = DEFAULT_COEF_W,
    parameter logic [NUM_TAPS*COEF_W-1:0]    COEFS       = DEFAULT_COEFS,
    parameter int                            SHIFT       = 0,
    parameter int                            SRC_BASE    = 0,
    parameter int                            DST_BASE    = 128
) (
    input  logic                  clk_input,
    input  logic                  rst_n_input,
    input  logic [31:0]           command_port,
    output logic [31:0]           status_port,
    output logic [ADDR_W-1:0]     master_address,
    output logic                  master_read,
    output logic                  master_write,
    input  logic [DATA_W-1:0]     master_readdata,
    output logic [DATA_W-1:0]     master_writedata,
    input  logic                  master_waitrequest,
    output logic [DATA_W/8-1:0]   master_byteen
);

    localparam logic [31:0]       MAX_N = 32'(MAX_SAMPLES);
    localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_BASE);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, idx_q, idx_inc;
    logic [CNT_W-1:0]   count_q;
    logic               error_q;
    logic [DATA_W-1:0]  sample_q;

    logic               cmd_req, cmd_abort, len_ok, last;
    logic [LEN_W-1:0]   cmd_len;
    logic               start, clear_stats, set_error, capture, mac_load, advance;
    logic [ADDR_W-1:0]  word_off;

    assign cmd_req   = command_port[CMD_REQ_BIT];
    assign cmd_abort = command_port[CMD_ABORT_BIT];
    assign cmd_len   = command_port[CMD_LEN_LSB +: LEN_W];
    assign len_ok    = (cmd_len != '0) && (32'(cmd_len) <= MAX_N);
    assign idx_inc   = idx_q + LEN_W'(1);
    assign last      = (idx_inc == len_q);

    // Abort is only looked at on the way into READ or WRITE, never mid-transfer.
    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        clear_stats = 1'b0;
        set_error   = 1'b0;
        capture     = 1'b0;
        mac_load    = 1'b0;
        advance     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_req) begin
                    clear_stats = 1'b1;
                    if (len_ok) begin
                        start = 1'b1;
                        if (cmd_abort) begin
                            set_error = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            state_d   = ST_READ;
                        end
                    end else begin
                        set_error = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (!master_waitrequest) begin
                    capture = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                mac_load = 1'b1;
                if (cmd_abort) begin
                    set_error = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!master_waitrequest) begin
                    advance = 1'b1;
                    if (last) begin
                        state_d = ST_DONE;
                    end else if (cmd_abort) begin
                        set_error = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                if (!cmd_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_input or negedge rst_n_input) begin
        if (!rst_n_input) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                len_q <= cmd_len;
                idx_q <= '0;
            end else if (advance) begin
                idx_q <= idx_inc;
            end
            if (clear_stats) begin
                count_q <= '0;
                error_q <= set_error;
            end else begin
                if (advance) begin
                    count_q <= count_q + CNT_W'(1);
                end
                if (set_error) begin
                    error_q <= 1'b1;
                end
            end
            if (capture) begin
                sample_q <= master_readdata;
            end
        end
    end

    fir_mac #(
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .NUM_TAPS (NUM_TAPS),
        .COEFS    (COEFS),
        .SHIFT    (SHIFT)
    ) u_mac (
        .clk    (clk_input),
        .rst_n  (rst_n_input),
        .clear  (start),
        .load   (mac_load),
        .sample (sample_q),
        .result (master_writedata)
    );

    // Bus outputs derive from registered state only, so they hold through stalls.
    assign word_off = ADDR_W'({idx_q, 2'b00});

    always_comb begin
        master_address = '0;
        if (state_q == ST_READ) begin
            master_address = SRC_A + word_off;
        end else if (state_q == ST_WRITE) begin
            master_address = DST_A + word_off;
        end
    end

    assign master_read   = (state_q == ST_READ);
    assign master_write  = (state_q == ST_WRITE);
    assign master_byteen = '1;

    assign status_port = pack_status(state_q == ST_DONE,
                                     state_q inside {ST_READ, ST_CALC, ST_WRITE},
                                     error_q,
                                     count_q);

endmodule

// File: tb/tb_mm_fir_accel.sv
// Self-checking bench for mm_fir_accel: Avalon slave with random stalls and a
// direct-form FIR reference model computed from the source samples.
module tb_mm_fir_accel;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 10;
    localparam int MAX_SAMPLES = 1024;
    localparam int SHIFT       = 0;
    localparam int DST_BYTE    = 128;

    logic                clk_input   = 1'b0;
    logic                rst_n_input = 1'b0;
    logic                req         = 1'b0;
    logic [15:0]         len         = '0;
    logic                abort_sig;
    logic [31:0]         command_port;
    logic [31:0]         status_port;
    logic [ADDR_W-1:0]   master_address;
    logic                master_read;
    logic                master_write;
    logic [DATA_W-1:0]   master_readdata    = '0;
    logic [DATA_W-1:0]   master_writedata;
    logic                master_waitrequest = 1'b0;
    logic [DATA_W/8-1:0] master_byteen;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave-side bookkeeping.
    logic [31:0] src_mem       [256];
    logic [9:0]  wr_addr_log   [4096];
    logic [31:0] wr_data_log   [4096];
    int          n_wr = 0, n_rd = 0;
    int          abort_at = 0;
    int          stall_min = 0, stall_max = 0;
    bit          in_xfer = 0;
    int          stall_left = 0;
    logic [9:0]  snap_addr;
    logic [31:0] snap_data;
    logic        snap_wr;

    // Run results.
    int          wr_base, rd_base, last_cycles;
    logic [31:0] last_sts;
    bit          last_busy;

    int coef [3] = '{1, 2, 1};

    assign abort_sig    = (abort_at != 0) && (n_wr >= abort_at);
    assign command_port = {len, 14'd0, abort_sig, req};

    mm_fir_accel dut (
        .clk_input          (clk_input),
        .rst_n_input        (rst_n_input),
        .command_port       (command_port),
        .status_port        (status_port),
        .master_address     (master_address),
        .master_read        (master_read),
        .master_write       (master_write),
        .master_readdata    (master_readdata),
        .master_writedata   (master_writedata),
        .master_waitrequest (master_waitrequest),
        .master_byteen      (master_byteen)
    );

    always #5 clk_input = ~clk_input;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave: picks a stall length per transfer, checks the master holds still.
    always @(negedge clk_input) begin
        if (!rst_n_input) begin
            in_xfer            = 0;
            master_waitrequest = 1'b0;
        end else if (master_read || master_write) begin
            if (!in_xfer) begin
                in_xfer    = 1;
                stall_left = $urandom_range(stall_min, stall_max);
                snap_addr  = master_address;
                snap_data  = master_writedata;
                snap_wr    = master_write;
            end else begin
                check("stall_addr", 32'(master_address), 32'(snap_addr));
                check("stall_strobe", {30'd0, master_read, master_write}, {30'd0, !snap_wr, snap_wr});
                if (snap_wr) check("stall_data", master_writedata, snap_data);
            end
            if (stall_left > 0) begin
                master_waitrequest = 1'b1;
                stall_left--;
            end else begin
                master_waitrequest = 1'b0;
                in_xfer            = 0;
                if (master_write) begin
                    wr_addr_log[n_wr] = master_address;
                    wr_data_log[n_wr] = master_writedata;
                    n_wr++;
                end else begin
                    master_readdata = src_mem[master_address[9:2]];
                    n_rd++;
                end
            end
        end else begin
            master_waitrequest = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [31:0] fir_ref(input int k);
        longint acc;
        acc = 0;
        for (int t = 0; t < 3; t++) begin
            if (k - t >= 0) acc += longint'(coef[t]) * longint'($signed(src_mem[k-t]));
        end
        acc = acc >>> SHIFT;
`ifdef MM_FIR_ACCEL_SAT_EN
        if (acc > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
        if (acc < -(64'sh80000000)) return 32'h80000000;
`endif
        return acc[31:0];
    endfunction

    task automatic run(input string tag, input int n, input int smin, input int smax,
                       input int abort_after);
        stall_min   = smin;
        stall_max   = smax;
        wr_base     = n_wr;
        rd_base     = n_rd;
        abort_at    = (abort_after > 0) ? n_wr + abort_after : 0;
        last_busy   = 0;
        last_cycles = 0;
        @(negedge clk_input);
        req = 1'b1;
        len = 16'(n);
        while (last_cycles < 3000) begin
            @(posedge clk_input);
            last_cycles++;
            @(negedge clk_input);
            req = 1'b0;
            if (status_port[1]) last_busy = 1;
            if (status_port[0]) break;
        end
        check({tag, "_ack"}, {31'd0, status_port[0]}, 32'd1);
        last_sts = status_port;
        abort_at = 0;
        @(negedge clk_input);
        check({tag, "_ack_pulse"}, {31'd0, status_port[0]}, 32'd0);
    endtask

    task automatic verify(input string tag, input int nw, input int nrd, input logic err);
        check({tag, "_writes"}, 32'(n_wr - wr_base), 32'(nw));
        check({tag, "_reads"}, 32'(n_rd - rd_base), 32'(nrd));
        check({tag, "_error"}, {31'd0, last_sts[2]}, {31'd0, err});
        check({tag, "_busy"}, {31'd0, last_sts[1]}, 32'd0);
        check({tag, "_count"}, {16'd0, last_sts[31:16]}, 32'(nw));
        for (int k = 0; k < nw; k++) begin
            check($sformatf("%s_addr%0d", tag, k), 32'(wr_addr_log[wr_base+k]), 32'(10'(DST_BYTE + 4*k)));
            check($sformatf("%s_y%0d", tag, k), wr_data_log[wr_base+k], fir_ref(k));
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) src_mem[i] = $urandom();
            else                           src_mem[i] = 32'($urandom_range(0, 200)) - 32'd100;
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) src_mem[i] = '0;

        // Reset state.
        repeat (3) @(negedge clk_input);
        check("rst_status", status_port, 32'd0);
        check("rst_strobes", {30'd0, master_read, master_write}, 32'd0);
        check("rst_addr", 32'(master_address), 32'd0);
        check("rst_wdata", master_writedata, 32'd0);
        check("rst_byteen", 32'(master_byteen), 32'hF);
        rst_n_input = 1'b1;
        repeat (2) @(negedge clk_input);

        // Impulse, no stalls: latency and response.
        src_mem[0] = 32'd1; src_mem[1] = 32'd0; src_mem[2] = 32'd0; src_mem[3] = 32'd0;
        run("imp", 4, 0, 0, 0);
        check("imp_cycles", 32'(last_cycles), 32'd13);
        check("imp_busy_seen", {31'd0, last_busy}, 32'd1);
        verify("imp", 4, 4, 1'b0);
        check("imp_y1_const", wr_data_log[wr_base+1], 32'd2);

        // Impulse with random stalls on every transfer.
        run("imp_stall", 4, 0, 5, 0);
        verify("imp_stall", 4, 4, 1'b0);

        // Positive full-scale input: saturate or wrap.
        src_mem[0] = 32'h7FFFFFFF; src_mem[1] = 32'h7FFFFFFF;
        run("sat", 2, 0, 2, 0);
        verify("sat", 2, 2, 1'b0);
`ifdef MM_FIR_ACCEL_SAT_EN
        check("sat_y1_const", wr_data_log[wr_base+1], 32'h7FFFFFFF);
`else
        check("sat_y1_const", wr_data_log[wr_base+1], 32'h7FFFFFFD);
`endif

        // Illegal lengths: immediate error, no traffic.
        run("len0", 0, 0, 0, 0);
        verify("len0", 0, 0, 1'b1);
        check("len0_cycles", 32'(last_cycles), 32'd1);
        check("len0_no_busy", {31'd0, last_busy}, 32'd0);
        run("lenmax", MAX_SAMPLES + 1, 0, 0, 0);
        verify("lenmax", 0, 0, 1'b1);

        // Abort after the second write; error and count must then hold.
        fill_random(4);
        run("abort", 4, 0, 3, 2);
        verify("abort", 2, 2, 1'b1);
        repeat (3) @(negedge clk_input);
        check("abort_hold_err", {31'd0, status_port[2]}, 32'd1);
        check("abort_hold_cnt", {16'd0, status_port[31:16]}, 32'd2);

        // Next run must start from zero history.
        src_mem[0] = 32'd1; src_mem[1] = 32'd0; src_mem[2] = 32'd0; src_mem[3] = 32'd0;
        run("post_abort", 4, 0, 0, 0);
        verify("post_abort", 4, 4, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 8);
            fill_random(n);
            run($sformatf("rnd%0d", r), n, 0, $urandom_range(0, 3), 0);
            verify($sformatf("rnd%0d", r), n, n, 1'b0);
        end

        // Reset while a write is stalled.
        fill_random(4);
        stall_min = 3;
        stall_max = 5;
        @(negedge clk_input);
        req   = 1'b1;
        len   = 16'd4;
        found = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk_input);
            req = 1'b0;
            #1;
            if (master_write && master_waitrequest) found = 1;
        end
        check("mrst_stall_seen", {31'd0, found}, 32'd1);
        #2 rst_n_input = 1'b0;
        #1;
        check("mrst_strobes", {30'd0, master_read, master_write}, 32'd0);
        check("mrst_status", status_port, 32'd0);
        check("mrst_addr", 32'(master_address), 32'd0);
        check("mrst_wdata", master_writedata, 32'd0);
        repeat (2) @(negedge clk_input);
        rst_n_input = 1'b1;
        stall_min   = 0;
        wr_base     = n_wr;
        repeat (5) @(negedge clk_input);
        check("mrst_quiet", {30'd0, master_read, master_write}, 32'd0);
        check("mrst_no_writes", 32'(n_wr - wr_base), 32'd0);
        fill_random(5);
        run("rerun", 5, 0, 2, 0);
        verify("rerun", 5, 5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
